// File: rtl/corelet_ctrl.sv
// corelet_ctrl: host-side sequencer for corelet (L0 fill, kernel load, execute, OFIFO drain).
// Define CORELET_CTRL_SFP_EN to feed each drained word to the SFP.
module corelet_ctrl #(
  parameter int bw = 4,
  parameter int psum_bw = 16,
  parameter int col = 8,
  parameter int row = 8,
  parameter int L0_DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             len,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bw*row-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [psum_bw*col-1:0] out_data,
  output logic [2:0]             inst_w,
  output logic                   l0_wr,
  output logic                   l0_rd,
  output logic [bw*row-1:0]      l0_wdata,
  input  logic                   l0_ready,
  output logic                   ififo_wr,
  output logic                   ififo_rd,
  output logic [bw*row-1:0]      ififo_wdata,
  output logic                   ofifo_rd,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] ofifo_rdata,
  output logic [psum_bw*col-1:0] sfp_psum,
  output logic                   sfp_acc
);
  localparam logic [2:0] IDLE = 3'd0, WLOAD = 3'd1, KLOAD = 3'd2, KTAIL = 3'd3, EXEC = 3'd4;
  localparam int OW = $clog2(L0_DEPTH) + 1;
  logic [2:0] state;
  logic [7:0] len_q, wcnt, tcnt, xwr, xrd, ocnt;
  logic [OW-1:0] occ;
  logic done_q, exec, hs, last;
  always_comb begin
    exec = state == EXEC;
    in_ready = state == WLOAD ? l0_ready : exec & l0_ready & (xwr < len_q);
    l0_wr = in_valid & in_ready;
    l0_rd = state == KLOAD | (exec & (occ != '0) & (xrd < len_q));
    ofifo_rd = exec & (len_q != 8'd0) & ofifo_valid & (!out_valid | out_ready);
    hs = exec & out_valid & out_ready;
    last = hs & (ocnt + 8'd1 == len_q);
  end
  assign busy = state != IDLE;
  assign done = done_q | (exec & (len_q == 8'd0));
  assign l0_wdata = in_data;
  assign ififo_wr = 1'b0;
  assign ififo_rd = 1'b0;
  assign ififo_wdata = '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      len_q <= '0;
      wcnt <= '0;
      tcnt <= '0;
      xwr <= '0;
      xrd <= '0;
      ocnt <= '0;
      occ <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      inst_w <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      // L0 data appears one cycle after the pop, so instructions trail l0_rd
      inst_w <= {1'b0, exec & l0_rd, state == KLOAD};
      occ <= occ + OW'(l0_wr) - OW'(l0_rd);
      out_valid <= ofifo_rd | (out_valid & !out_ready);
      if (ofifo_rd) out_data <= ofifo_rdata;
      else if (last) out_data <= '0;
      case (state)
        IDLE: if (start) begin
          state <= WLOAD;
          len_q <= len;
          wcnt <= '0;
          tcnt <= '0;
          xwr <= '0;
          xrd <= '0;
          ocnt <= '0;
          occ <= '0;
        end
        WLOAD: begin
          wcnt <= wcnt + 8'(l0_wr);
          if (l0_wr && wcnt == 8'(col - 1)) state <= KLOAD;
        end
        KLOAD: begin
          tcnt <= tcnt == 8'(col - 1) ? 8'd0 : tcnt + 8'd1;
          if (tcnt == 8'(col - 1)) state <= KTAIL;
        end
        KTAIL: begin
          tcnt <= tcnt + 8'd1;
          if (tcnt == 8'(row - 1)) state <= EXEC;
        end
        EXEC: begin
          xwr <= xwr + 8'(l0_wr);
          xrd <= xrd + 8'(l0_rd);
          ocnt <= ocnt + 8'(hs);
          if (last || len_q == 8'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CORELET_CTRL_SFP_EN
  logic acc_q;
  always_ff @(posedge clk) begin
    if (!reset) acc_q <= 1'b0;
    else acc_q <= ofifo_rd;
  end
  assign sfp_psum = out_data;
  assign sfp_acc = acc_q;
`else
  assign sfp_psum = '0;
  assign sfp_acc = 1'b0;
`endif
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: directed bench for corelet_ctrl with a small corelet-side model.
module tb_corelet_ctrl;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0] len = 8'd0;
  logic busy, done, in_ready, out_valid, l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, sfp_acc;
  logic in_valid = 1'b0, out_ready = 1'b0, l0_ready = 1'b0, ofifo_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] l0_wdata, ififo_wdata;
  logic [127:0] out_data, sfp_psum;
  logic [127:0] ofifo_rdata = '0;
  logic [2:0] inst_w;
  int cmp = 0, errs = 0;

  always #5 clk = ~clk;

  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .inst_w(inst_w),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_wdata(l0_wdata), .l0_ready(l0_ready),
    .ififo_wr(ififo_wr), .ififo_rd(ififo_rd), .ififo_wdata(ififo_wdata),
    .ofifo_rd(ofifo_rd), .ofifo_valid(ofifo_valid), .ofifo_rdata(ofifo_rdata),
    .sfp_psum(sfp_psum), .sfp_acc(sfp_acc)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] word(input int i);
    return {4{32'hA500_0000 + 32'(i) * 32'h1011}};
  endfunction

  task automatic load_phase(input int n);
    int bad = 0;
    start = 1'b1; len = 8'(n); l0_ready = 1'b1; out_ready = 1'b1;
    ofifo_valid = 1'b1; ofifo_rdata = word(99);
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 1);
      #1;
      if (i == 0) chk("busy_wload", busy, 1);
      chk("wload_wr", l0_wr, 1);
      chk("wload_data", l0_wdata, 32'(i + 1));
      bad += int'(ofifo_rd);
      tick;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("kload_rd", l0_rd, 1);
      chk("kload_inst", inst_w, k == 0 ? 3'b000 : 3'b001);
      chk("kload_in_ready", in_ready, 0);
      bad += int'(ofifo_rd);
      tick;
    end
    for (int t = 0; t < 8; t++) begin
      #1;
      chk("ktail_rd", l0_rd, 0);
      chk("ktail_inst", inst_w, t == 0 ? 3'b001 : 3'b000);
      bad += int'(ofifo_rd);
      tick;
    end
    chk("ofifo_rd_outside_exec", bad, 0);
  endtask

  task automatic exec_phase(input int n, input bit tog, input int stall_at);
    int wr = 0, rd = 0, ex = 0, sent = 0, hs = 0, acc = 0, cyc = 0, last_hs = -1;
    logic [127:0] held = '0;
    bit stalled = 1'b0, fin = 1'b0;
    while (!fin && cyc < 400) begin
      in_valid = wr < n; in_data = 32'h100 + 32'(wr);
      l0_ready = !(cyc >= stall_at && cyc < stall_at + 5);
      out_ready = tog ? cyc[0] : 1'b1;
      ofifo_valid = sent < ex || n == 0; ofifo_rdata = word(sent);
      #1;
      if (!l0_ready) chk("stall_in_ready", in_ready, 0);
      if (stalled && out_valid) chk("out_hold", out_data, held);
      if (sfp_acc) begin
        acc++;
`ifdef CORELET_CTRL_SFP_EN
        chk("sfp_psum", sfp_psum, word(hs));
`endif
      end
      if (done) begin
        fin = 1'b1;
        chk("done_cycle", cyc, last_hs + 1);
        if (n > 0) chk("busy_at_done", busy, 0);
      end
      if (out_valid && out_ready) begin
        chk("out_data", out_data, word(hs));
        hs++;
        last_hs = cyc;
      end
      wr += int'(l0_wr); rd += int'(l0_rd); ex += int'(inst_w[1]); sent += int'(ofifo_rd);
      stalled = out_valid && !out_ready; held = out_data;
      tick;
      cyc++;
    end
    in_valid = 1'b0; ofifo_valid = 1'b0;
    chk("exec_timeout", fin, 1);
    chk("hs_count", hs, n);
    chk("l0_pushes", wr, n);
    chk("l0_pops", rd, n);
    chk("exec_insts", ex, n);
    chk("ofifo_reads", sent, n);
    chk("occ_end", dut.occ, 0);
`ifdef CORELET_CTRL_SFP_EN
    chk("sfp_acc_count", acc, n);
`else
    chk("sfp_acc_never", acc, 0);
    chk("sfp_psum_zero", sfp_psum, 0);
`endif
    #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_inst", inst_w, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ofifo_rd", ofifo_rd, 0);
    reset = 1'b1;
    tick;
    load_phase(4);
    exec_phase(4, 1'b0, -100);
    load_phase(16);
    exec_phase(16, 1'b1, -100);
    load_phase(8);
    exec_phase(8, 1'b0, 2);
    load_phase(0);
    exec_phase(0, 1'b0, -100);
    load_phase(3);
    exec_phase(3, 1'b1, -100);
    // reset while a word sits in the output register
    load_phase(4);
    out_ready = 1'b0; ofifo_valid = 1'b1; ofifo_rdata = word(7);
    tick;
    chk("pre_reset_out_valid", out_valid, 1);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b0;
    tick;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_inst", inst_w, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ofifo_rd", ofifo_rd, 0);
    reset = 1'b1; ofifo_valid = 1'b0;
    tick;
    load_phase(4);
    exec_phase(4, 1'b0, -100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
